// File: rtl/multiport_regfile_if.sv
// Register-file port bundle: per-lane read pairs, writeback, issue and conflict flag.
// Lane i of every packed field occupies the slice [i*W +: W].
interface multiport_regfile_if #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AW        = 5
) ();
  logic [NUM_LANES*AW-1:0]   rs1_addr;
  logic [NUM_LANES*AW-1:0]   rs2_addr;
  logic [NUM_LANES*XLEN-1:0] rs1_data;
  logic [NUM_LANES*XLEN-1:0] rs2_data;
  logic [NUM_LANES-1:0]      rs1_busy;
  logic [NUM_LANES-1:0]      rs2_busy;
  logic [NUM_LANES-1:0]      wr_en;
  logic [NUM_LANES*AW-1:0]   wr_addr;
  logic [NUM_LANES*XLEN-1:0] wr_data;
  logic [NUM_LANES-1:0]      iss_en;
  logic [NUM_LANES*AW-1:0]   iss_rd;
  logic                      wr_conflict;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, wr_conflict
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, wr_conflict
  );
endinterface

// File: rtl/multiport_regfile.sv
// Multi-lane register file with write-first bypass, per-register busy scoreboard
// and a registered same-destination write conflict flag.
module multiport_regfile #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  multiport_regfile_if.slave rf
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             wr_conflict_q, wr_conflict_d;

  logic [AW-1:0]    wa [NUM_LANES];
  logic [XLEN-1:0]  wd [NUM_LANES];
  logic [AW-1:0]    ia [NUM_LANES];

  // Unpack lane-packed writeback and issue fields.
  always_comb begin
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      wa[l] = rf.wr_addr[l*AW +: AW];
      wd[l] = rf.wr_data[l*XLEN +: XLEN];
      ia[l] = rf.iss_rd[l*AW +: AW];
    end
  end

  // Next state: higher lanes overwrite lower ones; issue set is applied after write clear.
  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    wr_conflict_d = 1'b0;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      if (rf.wr_en[l] && (wa[l] != '0)) begin
        regs_d[wa[l]] = wd[l];
        busy_d[wa[l]] = 1'b0;
      end
    end
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      if (rf.iss_en[l] && (ia[l] != '0)) begin
        busy_d[ia[l]] = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      for (int j = i + 1; j < int'(NUM_LANES); j++) begin
        if (rf.wr_en[i] && rf.wr_en[j] && (wa[i] == wa[j]) && (wa[i] != '0)) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs_q[r] <= '0;
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign rf.wr_conflict = wr_conflict_q;

  // Per-lane read ports; reset forces zero so in-flight writeback cannot bypass through.
  for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_rd
    logic [AW-1:0]   a1, a2;
    logic [XLEN-1:0] d1, d2;
    logic            h1, h2;

    always_comb begin
      a1 = rf.rs1_addr[g*AW +: AW];
      a2 = rf.rs2_addr[g*AW +: AW];
      d1 = regs_q[a1];
      d2 = regs_q[a2];
      h1 = 1'b0;
      h2 = 1'b0;
      for (int w = 0; w < int'(NUM_LANES); w++) begin
        if (rf.wr_en[w] && (wa[w] != '0)) begin
          if (wa[w] == a1) begin
            d1 = wd[w];
            h1 = 1'b1;
          end
          if (wa[w] == a2) begin
            d2 = wd[w];
            h2 = 1'b1;
          end
        end
      end
      if (!rst_n || (a1 == '0)) begin
        d1 = '0;
      end
      if (!rst_n || (a2 == '0)) begin
        d2 = '0;
      end
    end

    assign rf.rs1_data[g*XLEN +: XLEN] = d1;
    assign rf.rs2_data[g*XLEN +: XLEN] = d2;
    assign rf.rs1_busy[g] = rst_n && (a1 != '0) && busy_q[a1] && !h1;
    assign rf.rs2_busy[g] = rst_n && (a2 != '0) && busy_q[a2] && !h2;
  end
endmodule
